// File: rtl/pattern_embed_tx_pkg.sv
// Shared definitions for the pattern embed transmitter and the receive-side matcher.
package pattern_pkg;

    localparam int DATA_W  = 8;
    localparam int PAT_W   = 4;
    localparam int POS_W   = 3;
    localparam int MAX_POS = DATA_W - PAT_W;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_e;

    function automatic logic [DATA_W-1:0] insert(
        input logic [DATA_W-1:0] base,
        input logic [PAT_W-1:0]  pat,
        input logic [POS_W-1:0]  pos
    );
        logic [DATA_W-1:0] field;
        field  = DATA_W'({PAT_W{1'b1}}) << pos;
        insert = (base & ~field) | (DATA_W'(pat) << pos);
    endfunction

endpackage

// File: rtl/pattern_embed_tx_if.sv
// Request and serial-link signals of the pattern embed transmitter.
interface pattern_embed_tx_if #(
    parameter int DATA_W = pattern_pkg::DATA_W,
    parameter int PAT_W  = pattern_pkg::PAT_W,
    parameter int POS_W  = pattern_pkg::POS_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] base;
    logic [PAT_W-1:0]  pat;
    logic [POS_W-1:0]  pos;
    logic              ser_out;
    logic              ser_valid;
    logic              ser_ready;
    logic              ser_last;
    logic [DATA_W-1:0] word_out;
    logic [POS_W-1:0]  pos_out;
    logic              done;
    logic              err;

    modport slave (
        input  in_valid, base, pat, pos, ser_ready,
        output in_ready, ser_out, ser_valid, ser_last, word_out, pos_out, done, err
    );

    modport master (
        output in_valid, base, pat, pos, ser_ready,
        input  in_ready, ser_out, ser_valid, ser_last, word_out, pos_out, done, err
    );
endinterface

// File: rtl/pattern_embed_tx_insert.sv
// Combinational composer: overlays the pattern onto the base word and flags illegal offsets.
module pattern_insert #(
    parameter int DATA_W = pattern_pkg::DATA_W,
    parameter int PAT_W  = pattern_pkg::PAT_W,
    parameter int POS_W  = pattern_pkg::POS_W
) (
    input  logic [DATA_W-1:0] base_i,
    input  logic [PAT_W-1:0]  pat_i,
    input  logic [POS_W-1:0]  pos_i,
    output logic [DATA_W-1:0] word_o,
    output logic              pos_ok_o
);
    localparam logic [DATA_W-1:0] FIELD     = DATA_W'({PAT_W{1'b1}});
    localparam logic [POS_W-1:0]  LEGAL_MAX = POS_W'(DATA_W - PAT_W);

    always_comb begin
        word_o   = (base_i & ~(FIELD << pos_i)) | (DATA_W'(pat_i) << pos_i);
        pos_ok_o = (pos_i <= LEGAL_MAX);
    end
endmodule

// File: rtl/pattern_embed_tx.sv
// Pattern embed transmitter: composes base+pattern and shifts the word out LSB-first.
module pattern_embed_tx #(
    parameter int DATA_W = pattern_pkg::DATA_W,
    parameter int PAT_W  = pattern_pkg::PAT_W,
    parameter int POS_W  = pattern_pkg::POS_W
) (
    input  logic              clk,
    input  logic              rst_n,
    pattern_embed_tx_if.slave bus
);
    import pattern_pkg::*;

    localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] ins_word;
    logic              ins_ok;

    pattern_insert #(
        .DATA_W (DATA_W),
        .PAT_W  (PAT_W),
        .POS_W  (POS_W)
    ) u_insert (
        .base_i   (bus.base),
        .pat_i    (bus.pat),
        .pos_i    (bus.pos),
        .word_o   (ins_word),
        .pos_ok_o (ins_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            pos_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        pos_d   = pos_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (ins_ok) begin
                        word_d  = ins_word;
                        pos_d   = bus.pos;
                        shift_d = ins_word;
                        cnt_d   = '0;
                        state_d = SEND;
                    end else begin
                        // Illegal offset: request is consumed, only the error pulse is raised.
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (bus.ser_ready) begin
                    shift_d = shift_q >> 1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All link outputs decode registered state, so ser_ready never reaches them combinationally.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.ser_valid = (state_q == SEND);
    assign bus.ser_out   = shift_q[0];
    assign bus.ser_last  = (state_q == SEND) && (cnt_q == LAST_CNT);
    assign bus.word_out  = word_q;
    assign bus.pos_out   = pos_q;
    assign bus.done      = (state_q == DONE);
    assign bus.err       = err_q;
endmodule

// File: tb/tb_pattern_embed_tx.sv
// Self-checking bench for pattern_embed_tx: queue-based frame model plus directed literal checks.
module tb_pattern_embed_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pattern_embed_tx_if bus ();

    pattern_embed_tx #(
        .DATA_W (8),
        .PAT_W  (4),
        .POS_W  (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rmode = 0;
    int stall_cnt = 0;
    int done_cnt  = 0;
    bit cap[$];
    int last_at[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ser_ready driver: 0 = always ready, 1 = random, 2 = three-cycle stall at bit 2
    always @(posedge clk) begin
        int hold;
        #1;
        if (rmode != 2) hold = 0;
        case (rmode)
            1: bus.ser_ready = (($urandom % 4) != 0);
            2: begin
                if ((cap.size() % 8) == 2 && hold < 3) begin
                    bus.ser_ready = 1'b0;
                    hold++;
                end else begin
                    bus.ser_ready = 1'b1;
                end
            end
            default: bus.ser_ready = 1'b1;
        endcase
    end

    // Record every bit that will handshake on the next rising edge
    always @(negedge clk) begin
        if (rst_n && bus.ser_valid === 1'b1) begin
            if (bus.ser_ready === 1'b1) begin
                cap.push_back(bus.ser_out);
                if (bus.ser_last === 1'b1) last_at.push_back(cap.size() - 1);
            end else begin
                stall_cnt++;
            end
        end
        if (rst_n && bus.done === 1'b1) done_cnt++;
    end

    // Reference model: a frame is a queue of pending bits; done/err are one-cycle flags
    bit         m_q[$];
    bit         m_done = 1'b0;
    bit         m_err  = 1'b0;
    logic [7:0] m_word = 8'h00;
    logic [2:0] m_pos  = 3'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_done = 1'b0;
            m_err  = 1'b0;
            m_word = 8'h00;
            m_pos  = 3'd0;
        end else if (m_q.size() > 0) begin
            m_err = 1'b0;
            if (bus.ser_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else begin
            m_err = 1'b0;
            if (bus.in_valid) begin
                int p, pt, bs;
                p  = int'(bus.pos);
                pt = int'(bus.pat);
                bs = int'(bus.base);
                if (p > 4) begin
                    m_err = 1'b1;
                end else begin
                    m_pos = bus.pos;
                    for (int b = 0; b < 8; b++) begin
                        if (b >= p && b < p + 4) m_word[b] = 1'((pt >> (b - p)) & 1);
                        else                     m_word[b] = 1'((bs >> b) & 1);
                    end
                    for (int b = 0; b < 8; b++) m_q.push_back(m_word[b]);
                end
            end
        end
    end

    always @(negedge clk) begin
        bit ev, eo, el, er;
        ev = (m_q.size() > 0);
        eo = ev ? m_q[0] : 1'b0;
        el = (m_q.size() == 1);
        er = !ev && !m_done;
        chk("in_ready",  32'(bus.in_ready),  32'(er));
        chk("ser_valid", 32'(bus.ser_valid), 32'(ev));
        chk("ser_out",   32'(bus.ser_out),   32'(eo));
        chk("ser_last",  32'(bus.ser_last),  32'(el));
        chk("done",      32'(bus.done),      32'(m_done));
        chk("err",       32'(bus.err),       32'(m_err));
        chk("word_out",  32'(bus.word_out),  32'(m_word));
        chk("pos_out",   32'(bus.pos_out),   32'(m_pos));
    end

    task automatic do_frame(input logic [7:0] b, input logic [3:0] p, input logic [2:0] q,
                            output int n, output int d_at, output int st);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.base = b;
        bus.pat  = p;
        bus.pos  = q;
        n  = cyc;
        st = cap.size();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.base = 8'($urandom);
        bus.pat  = 4'($urandom);
        bus.pos  = 3'($urandom);
        d_at = -1;
        for (int i = 0; i < 200 && d_at < 0; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) d_at = cyc;
        end
    endtask

    function automatic logic [7:0] frame_word(input int st);
        logic [7:0] w;
        w = 8'h00;
        for (int i = 0; i < 8; i++) if (st + i < cap.size()) w[i] = cap[st + i];
        return w;
    endfunction

    initial begin
        int n, d_at, st, s0, dc0;
        logic [7:0] w;

        bus.in_valid = 1'b0;
        bus.base = 8'h00;
        bus.pat  = 4'h0;
        bus.pos  = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_word_out", 32'(bus.word_out), 32'h00);
        #1 rst_n = 1'b1;

        // base 00, pat A, pos 2 -> 0x28, bits 0,0,0,1,0,1,0,0
        do_frame(8'h00, 4'hA, 3'd2, n, d_at, st);
        chk("t1_word", 32'(bus.word_out), 32'h28);
        chk("t1_bits", 32'(frame_word(st)), 32'h28);
        chk("t1_nbits", 32'(cap.size() - st), 32'd8);
        chk("t1_last_idx", 32'(last_at[$]), 32'(st + 7));
        chk("t1_done_cyc", 32'(d_at), 32'(n + 9));
        chk("t1_busy_at_done", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("t1_ready_cyc", 32'(cyc), 32'(n + 10));
        chk("t1_ready", 32'(bus.in_ready), 32'd1);

        // base FF, pat 0, pos 4 -> 0x0F
        do_frame(8'hFF, 4'h0, 3'd4, n, d_at, st);
        chk("t2_word", 32'(bus.word_out), 32'h0F);
        chk("t2_bits", 32'(frame_word(st)), 32'h0F);
        chk("t2_done_cyc", 32'(d_at), 32'(n + 9));

        // Illegal offset 5: error pulse only, held outputs untouched
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.base = 8'h5A;
        bus.pat  = 4'h3;
        bus.pos  = 3'd5;
        n  = cyc;
        st = cap.size();
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t3_err_cyc", 32'(cyc), 32'(n + 1));
        chk("t3_err", 32'(bus.err), 32'd1);
        chk("t3_valid", 32'(bus.ser_valid), 32'd0);
        chk("t3_ready", 32'(bus.in_ready), 32'd1);
        chk("t3_word", 32'(bus.word_out), 32'h0F);
        chk("t3_pos", 32'(bus.pos_out), 32'd4);
        @(negedge clk);
        chk("t3_err_clear", 32'(bus.err), 32'd0);
        chk("t3_nobits", 32'(cap.size() - st), 32'd0);

        // Backpressure: three stalled cycles while bit 2 is presented
        rmode = 2;
        s0 = stall_cnt;
        do_frame(8'h00, 4'hF, 3'd0, n, d_at, st);
        rmode = 0;
        chk("t4_word", 32'(bus.word_out), 32'h0F);
        chk("t4_bits", 32'(frame_word(st)), 32'h0F);
        chk("t4_nbits", 32'(cap.size() - st), 32'd8);
        chk("t4_stalls", 32'(stall_cnt - s0), 32'd3);
        chk("t4_done_cyc", 32'(d_at), 32'(n + 12));

        // Reset after bit 4 of a frame: immediate reset values, no done
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.base = 8'hC3;
        bus.pat  = 4'h9;
        bus.pos  = 3'd1;
        st = cap.size();
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int i = 0; i < 50 && cap.size() < st + 5; i++) @(negedge clk);
        chk("t5_reached_bit4", 32'(cap.size() - st), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(bus.ser_valid), 32'd0);
        chk("t5_ready", 32'(bus.in_ready), 32'd1);
        chk("t5_out", 32'(bus.ser_out), 32'd0);
        chk("t5_last", 32'(bus.ser_last), 32'd0);
        chk("t5_word", 32'(bus.word_out), 32'h00);
        chk("t5_pos", 32'(bus.pos_out), 32'd0);
        chk("t5_done", 32'(bus.done), 32'd0);
        chk("t5_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        dc0 = done_cnt;
        repeat (12) @(negedge clk);
        chk("t5_no_done", 32'(done_cnt - dc0), 32'd0);
        do_frame(8'h81, 4'h6, 3'd3, n, d_at, st);
        chk("t5_new_word", 32'(bus.word_out), 32'hB1);
        chk("t5_new_bits", 32'(frame_word(st)), 32'hB1);
        chk("t5_new_done", 32'(d_at), 32'(n + 9));

        // Loopback: deserialise each frame and look for the pattern at its offset
        for (int p = 0; p < 16; p++) begin
            for (int q = 0; q < 5; q++) begin
                do_frame(8'($urandom), 4'(p), 3'(q), n, d_at, st);
                w = frame_word(st);
                chk("loop_nbits", 32'(cap.size() - st), 32'd8);
                chk("loop_match", 32'((w >> q) & 8'h0F), 32'(p));
            end
        end

        // Random traffic with random backpressure; the model checks every cycle
        rmode = 1;
        dc0 = done_cnt;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = (($urandom % 3) == 0);
            bus.base = 8'($urandom);
            bus.pat  = 4'($urandom);
            bus.pos  = 3'($urandom);
        end
        bus.in_valid = 1'b0;
        rmode = 0;
        repeat (30) @(negedge clk);
        total++;
        if (done_cnt - dc0 < 10) begin
            bad++;
            $display("FAIL rand_frames: got %0d expected at least 10", done_cnt - dc0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
